// File: rtl/md_hazard_unit_pkg.sv
// Shared MIPS definitions used by the multiply/divide hazard unit:
// opcode/funct codes, MDU latency defaults and the decode result type.
package md_hazard_unit_pkg;

  localparam logic [5:0] OP_SPECIAL  = 6'h00;
  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN2_MADD = 6'h00;

  localparam int unsigned MULT_LAT_DEF = 5;
  localparam int unsigned DIV_LAT_DEF  = 10;

  localparam int unsigned LEFT_W = 4;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic md_class;
    logic is_mult;
    logic is_div;
  } md_class_t;

  // SPECIAL functs that touch HI/LO: mfhi..mtlo and mult..divu.
  function automatic logic special_md_funct(input logic [5:0] fn);
    return ((fn >= FN_MFHI) && (fn <= FN_MTLO)) ||
           ((fn >= FN_MULT) && (fn <= FN_DIVU));
  endfunction

endpackage

// File: rtl/md_hazard_unit_md_decode.sv
// Combinational HI/LO-class decode of one instruction word; also flags
// which MDU operation (multiply or divide) it starts.
module md_decode
  import md_hazard_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  output md_class_t   cls_o
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       instr_unused;

  assign op           = instr_i[31:26];
  assign fn           = instr_i[5:0];
  assign instr_unused = ^instr_i[25:6];

  always_comb begin
    cls_o = '0;
    if (op == OP_SPECIAL) begin
      cls_o.md_class = special_md_funct(fn);
      cls_o.is_mult  = (fn == FN_MULT) || (fn == FN_MULTU);
      cls_o.is_div   = (fn == FN_DIV)  || (fn == FN_DIVU);
    end else if (op == OP_SPECIAL2) begin
      cls_o.md_class = (fn == FN2_MADD);
    end
  end

endmodule

// File: rtl/md_hazard_unit.sv
// Decode-stage stall for HI/LO consumers while the multiply/divide unit is
// busy, with a shadow busy countdown, consistency flag and stall counter.
module md_hazard_unit
  import md_hazard_unit_pkg::*;
#(
  parameter int unsigned MULT_LAT = MULT_LAT_DEF,
  parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       instrD,
  input  logic [31:0]       instrE,
  input  logic              startE,
  input  logic              busyE,
  input  logic              IntReq,
  output logic              stallD,
  output logic [LEFT_W-1:0] mdLeft,
  output logic              mdErr,
  output logic [CNT_W-1:0]  stallCnt
);

  localparam logic [LEFT_W-1:0] MULT_LAT_L = LEFT_W'(MULT_LAT);
  localparam logic [LEFT_W-1:0] DIV_LAT_L  = LEFT_W'(DIV_LAT);

  md_class_t cls_d;
  md_class_t cls_e;
  logic      decode_d_unused;

  md_decode u_decode_d (
    .instr_i (instrD),
    .cls_o   (cls_d)
  );

  md_decode u_decode_e (
    .instr_i (instrE),
    .cls_o   (cls_e)
  );

  assign decode_d_unused = cls_d.is_mult ^ cls_d.is_div;

  logic [LEFT_W-1:0] md_left_q, md_left_d;
  logic              md_err_q,  md_err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic start_ok;
  logic left_nz;

  // An interrupt cancels the start: it neither loads the countdown nor stalls.
  assign start_ok = startE & ~IntReq;
  assign left_nz  = |md_left_q;
  assign stallD   = cls_d.md_class & (start_ok | busyE | left_nz);

  always_comb begin
    md_left_d = md_left_q;
    if (start_ok) begin
      if (cls_e.md_class && cls_e.is_mult) begin
        md_left_d = MULT_LAT_L;
      end else if (cls_e.md_class && cls_e.is_div) begin
        md_left_d = DIV_LAT_L;
      end else begin
        md_left_d = '0;
      end
    end else if (left_nz) begin
      md_left_d = md_left_q - {{(LEFT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky: a restart over a live countdown, or shadow count and busyE disagreeing.
  always_comb begin
    md_err_d = md_err_q
             | (start_ok & left_nz)
             | (left_nz & ~busyE)
             | (~left_nz & busyE);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stallD && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_left_q   <= '0;
      md_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      md_left_q   <= md_left_d;
      md_err_q    <= md_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mdLeft   = md_left_q;
  assign mdErr    = md_err_q;
  assign stallCnt = stall_cnt_q;

endmodule

// File: tb/tb_md_hazard_unit.sv
// Bench for md_hazard_unit: directed scenarios with literal expectations plus
// randomized traffic compared each cycle against a behavioural model.
module tb_md_hazard_unit;

  localparam int ML = 5;
  localparam int DL = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instrD = '0;
  logic [31:0] instrE = '0;
  logic        startE = 1'b0;
  logic        busyE = 1'b0;
  logic        IntReq = 1'b0;
  logic        stallD;
  logic [3:0]  mdLeft;
  logic        mdErr;
  logic [15:0] stallCnt;

  md_hazard_unit #(.MULT_LAT(ML), .DIV_LAT(DL)) dut (
    .clk      (clk),
    .reset    (reset),
    .instrD   (instrD),
    .instrE   (instrE),
    .startE   (startE),
    .busyE    (busyE),
    .IntReq   (IntReq),
    .stallD   (stallD),
    .mdLeft   (mdLeft),
    .mdErr    (mdErr),
    .stallCnt (stallCnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rt(input int op, input int fn);
    logic [5:0] o;
    logic [5:0] f;
    o = 6'(op);
    f = 6'(fn);
    return {o, 5'd8, 5'd9, 5'd10, 5'd0, f};
  endfunction

  logic [31:0] MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU, MADD, ADDU, MSUB, NOP;

  // ---------------- behavioural model ----------------
  int m_left = 0;
  int m_cnt  = 0;
  bit m_err  = 0;

  function automatic bit is_md(input logic [31:0] i);
    int op;
    int fn;
    op = int'(i[31:26]);
    fn = int'(i[5:0]);
    if (op == 0) return (fn >= 16 && fn <= 19) || (fn >= 24 && fn <= 27);
    if (op == 28) return fn == 0;
    return 0;
  endfunction

  function automatic int lat_of(input logic [31:0] i);
    int fn;
    fn = int'(i[5:0]);
    if (fn == 24 || fn == 25) return ML;
    if (fn == 26 || fn == 27) return DL;
    return 0;
  endfunction

  function bit model_stall();
    return is_md(instrD) && ((startE && !IntReq) || busyE || m_left != 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_cnt  <= 0;
      m_err  <= 0;
    end else begin
      if (model_stall() && m_cnt < 65535) m_cnt <= m_cnt + 1;
      if (((startE && !IntReq) && m_left != 0) || ((m_left != 0) != busyE)) m_err <= 1;
      if (startE && !IntReq) m_left <= lat_of(instrE);
      else if (m_left > 0)   m_left <= m_left - 1;
    end
  end

  bit cmp_en = 0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model stallD", stallD, model_stall());
      chk("model mdLeft", mdLeft, m_left);
      chk("model mdErr", mdErr, m_err);
      chk("model stallCnt", stallCnt, m_cnt);
    end
  end

  // One clock: drive at posedge+1, sample stallD mid-cycle, return at next posedge+1.
  task automatic cyc(input logic [31:0] d, input logic [31:0] e,
                     input logic st, input logic bz, input logic irq, output logic s);
    instrD = d;
    instrE = e;
    startE = st;
    busyE  = bz;
    IntReq = irq;
    @(negedge clk);
    s = stallD;
    @(posedge clk);
    #1;
  endtask

  // Start in cycle 0, busy for lat cycles, then one idle cycle.
  task automatic run_md(input string name, input logic [31:0] d, input logic [31:0] e,
                        input int lat, output int nstall);
    logic s;
    nstall = 0;
    for (int i = 0; i <= lat + 1; i++) begin
      cyc(d, (i == 0) ? e : NOP, i == 0, (i >= 1 && i <= lat), 1'b0, s);
      nstall += int'(s);
      chk({name, " mdLeft"}, mdLeft, (i <= lat) ? lat - i : 0);
    end
  endtask

  logic [31:0] pool [12];
  logic [31:0] starts [4];

  initial begin
    logic s;
    int   n;
    int   mdu_rem;
    logic [31:0] d, e;
    logic st, bz, irq;

    MFHI = rt(0, 16); MTHI = rt(0, 17); MFLO = rt(0, 18); MTLO = rt(0, 19);
    MULT = rt(0, 24); MULTU = rt(0, 25); DIV = rt(0, 26); DIVU = rt(0, 27);
    MADD = rt(28, 0); MSUB = rt(28, 4); ADDU = rt(0, 33); NOP = 32'h0;
    pool = '{MFHI, MTHI, MFLO, MTLO, MULT, MULTU, DIV, DIVU, MADD, ADDU, MSUB, rt(0, 20)};
    starts = '{MULT, MULTU, DIV, DIVU};

    // Reset state and reset-time stall dependence on inputs only.
    #2;
    chk("reset mdLeft", mdLeft, 0);
    chk("reset mdErr", mdErr, 0);
    chk("reset stallCnt", stallCnt, 0);
    chk("reset stallD idle", stallD, 0);
    instrD = MFLO; busyE = 1'b1;
    #1;
    chk("reset stallD busy", stallD, 1);
    busyE = 1'b0;
    #1;
    chk("reset stallD clear", stallD, 0);
    cmp_en = 1;
    @(posedge clk); #1;
    reset = 1'b1;

    run_md("mult/mflo", MFLO, MULT, ML, n);
    chk("mult/mflo stalls", n, 6);
    chk("mult/mflo stallCnt", stallCnt, 6);
    chk("mult/mflo mdErr", mdErr, 0);

    run_md("div/mfhi", MFHI, DIV, DL, n);
    chk("div/mfhi stalls", n, 11);
    chk("div/mfhi mdErr", mdErr, 0);
    chk("div/mfhi stallCnt", stallCnt, 17);

    cyc(MTHI, MULT, 1'b1, 1'b0, 1'b1, s);
    chk("cancel stallD", s, 0);
    chk("cancel mdLeft", mdLeft, 0);
    cyc(MTHI, NOP, 1'b0, 1'b0, 1'b0, s);
    chk("cancel mdLeft after", mdLeft, 0);

    cyc(NOP, DIV, 1'b1, 1'b0, 1'b0, s);
    for (int i = 0; i < 7; i++) cyc(NOP, NOP, 1'b0, 1'b1, 1'b0, s);
    chk("addu mdLeft 3", mdLeft, 3);
    for (int i = 0; i < 3; i++) begin
      cyc(ADDU, NOP, 1'b0, 1'b1, 1'b0, s);
      chk("addu stallD", s, 0);
    end
    chk("addu mdLeft 0", mdLeft, 0);
    cyc(NOP, NOP, 1'b0, 1'b0, 1'b0, s);
    chk("addu mdErr", mdErr, 0);
    chk("addu stallCnt", stallCnt, 17);

    cyc(NOP, MULT, 1'b1, 1'b0, 1'b0, s);
    for (int i = 0; i < ML; i++) cyc(NOP, NOP, 1'b0, 1'b1, 1'b0, s);
    chk("overbusy pre mdErr", mdErr, 0);
    cyc(NOP, NOP, 1'b0, 1'b1, 1'b0, s);
    chk("overbusy mdErr", mdErr, 1);
    for (int i = 0; i < 3; i++) cyc(NOP, NOP, 1'b0, 1'b0, 1'b0, s);
    chk("overbusy mdErr sticky", mdErr, 1);

    cyc(NOP, DIV, 1'b1, 1'b0, 1'b0, s);
    for (int i = 0; i < 3; i++) cyc(NOP, NOP, 1'b0, 1'b1, 1'b0, s);
    chk("midreset mdLeft 7", mdLeft, 7);
    #2;
    instrD = MFLO; busyE = 1'b0;
    reset = 1'b0;
    #1;
    chk("midreset mdLeft async", mdLeft, 0);
    chk("midreset mdErr", mdErr, 0);
    chk("midreset stallCnt", stallCnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(MFLO, NOP, 1'b0, 1'b0, 1'b0, s);
      chk("midreset no stall", s, 0);
      chk("midreset mdLeft stays", mdLeft, 0);
    end

    // Randomized traffic against a plausible MDU with occasional faults.
    mdu_rem = 0;
    for (int c = 0; c < 3000; c++) begin
      d = ($urandom_range(0, 7) == 0) ? $urandom : pool[$urandom_range(0, 11)];
      st = ($urandom_range(0, 5) == 0) && (mdu_rem == 0 || $urandom_range(0, 9) == 0);
      e = st ? starts[$urandom_range(0, 3)] : pool[$urandom_range(0, 11)];
      irq = ($urandom_range(0, 5) == 0);
      bz = (mdu_rem > 0);
      if ($urandom_range(0, 99) == 0) bz = ~bz;
      cyc(d, e, st, bz, irq, s);
      if (st && !irq) mdu_rem = lat_of(e);
      else if (mdu_rem > 0) mdu_rem--;
      if ($urandom_range(0, 199) == 0) begin
        #2;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        mdu_rem = 0;
      end
    end

    // Saturation of the stall counter.
    #2;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 65535; i++) cyc(MFLO, NOP, 1'b0, 1'b1, 1'b0, s);
    chk("sat stallCnt full", stallCnt, 16'hFFFF);
    chk("sat mdErr", mdErr, 1);
    cyc(MFLO, NOP, 1'b0, 1'b1, 1'b0, s);
    chk("sat stallD", s, 1);
    chk("sat stallCnt hold", stallCnt, 16'hFFFF);

    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_hazard_unit.md
MD_HAZARD_UNIT -- requirements
Module: md_hazard_unit

Interface
REQ-001 Parameters SHALL be: MULT_LAT, default 5, MDU busy cycles for mult/multu; DIV_LAT, default 10, MDU busy cycles for div/divu.
REQ-002 Port clk  input  1  the single pipeline clock; all state changes on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset.
REQ-004 Port instrD  input  32  instruction in the decode stage.
REQ-005 Port instrE  input  32  instruction in the execute stage, i.e. the one presented to the multiply/divide unit.
REQ-006 Port startE  input  1  multiply/divide unit start (mult/multu/div/divu in E).
REQ-007 Port busyE  input  1  multiply/divide unit busy.
REQ-008 Port IntReq  input  1  interrupt request; a start under IntReq is cancelled.
REQ-009 Port stallD  output  1  freeze PC and the F/D register, and insert a bubble into D/E.
REQ-010 Port mdLeft  output  4  shadow count of remaining MDU busy cycles.
REQ-011 Port mdErr  output  1  sticky flag: shadow count disagrees with busyE.
REQ-012 Port stallCnt  output  16  saturating count of MD-induced stall cycles.

Function
REQ-013 The unit SHALL classify instrD as MD-class when it is SPECIAL (opcode 0x00) with funct 0x10-0x13 or 0x18-0x1B, or SPECIAL2 (opcode 0x1C) with funct 0x00 (madd).
REQ-014 The unit SHALL assert stallD combinationally when instrD is MD-class and any of these hold: (startE and not IntReq), busyE, or mdLeft not 0.
REQ-015 stallD SHALL be 0 whenever instrD is not MD-class, regardless of MDU state.
REQ-016 On a clock edge with startE=1 and IntReq=0, mdLeft SHALL load the latency for instrE: funct 0x18/0x19 loads MULT_LAT, funct 0x1A/0x1B loads DIV_LAT.
REQ-017 On any other edge where mdLeft is not 0, mdLeft SHALL decrement by 1; mdLeft SHALL never wrap below 0.
REQ-018 A start arriving while mdLeft is not 0 SHALL reload mdLeft, so the latest start wins, and SHALL set mdErr.
REQ-019 startE with IntReq=1 SHALL leave mdLeft unchanged; a cancelled start SHALL never stall D.
REQ-020 On each edge where mdLeft is not 0, busyE SHALL equal 1; otherwise mdErr SHALL be set on that edge.
REQ-021 On an edge where mdLeft is 0, busyE=1 SHALL set mdErr; mdErr SHALL clear only on reset.
REQ-022 stallCnt SHALL increment on each edge where stallD=1, and SHALL saturate at 0xFFFF.
REQ-023 The stall window SHALL be exactly LAT+1 cycles from the cycle in which startE is asserted: one cycle of startE plus LAT cycles of busy.

Reset
REQ-024 While reset=0, the unit SHALL hold mdLeft=0, mdErr=0 and stallCnt=0, and stallD SHALL then depend only on startE, IntReq and busyE.
REQ-025 Reset asserted mid-countdown SHALL clear mdLeft immediately, and the countdown SHALL NOT resume after release.

Structure
REQ-026 Opcode/funct constants (SPECIAL, SPECIAL2, funct codes) and the MULT_LAT/DIV_LAT defaults SHALL live in the shared MIPS definitions package.
REQ-027 MD-class decode SHALL be a separate combinational sub-module, md_decode, instantiated once for instrD and once for instrE.

Verification
REQ-028 mult in E, startE=1, followed by mflo in D: stallD=1 for 6 consecutive cycles, then 0; mdLeft sequence is 5,4,3,2,1,0; stallCnt=6.
REQ-029 div followed by mfhi: stallD high for 11 cycles; mdErr stays 0 when busyE is driven 10 cycles.
REQ-030 mult with IntReq=1 in the start cycle, mthi in D: stallD=0, mdLeft stays 0.
REQ-031 addu in D while busyE=1 and mdLeft=3: stallD=0; mdLeft decrements to 0.
REQ-032 reset=0 pulse while mdLeft=7 (divide): mdLeft=0 asynchronously, with no stall after release when busyE=0.
REQ-033 busyE held 1 for one extra cycle after mdLeft reaches 0: mdErr=1 and it stays set; stallCnt forced to 0xFFFF saturates on the next stall.
